// File: rtl/instruction_decoder_if.sv
// Sequencer/datapath side bus of the nanoprocessor instruction decoder.
// No backpressure: pm_data is taken every edge; ir_valid qualifies every decoded control.
interface instruction_decoder_if;
    logic [7:0] pm_data;
    logic       alu_zero;
    logic       sync_reset;
    logic       jmp;
    logic       jmp_nz;
    logic [3:0] jmp_addr;
    logic       dont_jmp;
    logic [7:0] reg_en;
    logic [3:0] src_sel;
    logic [3:0] imm;
    logic       alu_en;
    logic [2:0] alu_func;
    logic       x_sel;
    logic       y_sel;
    logic       ir_valid;
    logic [7:0] ir;

    modport master (
        input  pm_data, alu_zero,
        output sync_reset, jmp, jmp_nz, jmp_addr, dont_jmp,
        output reg_en, src_sel, imm, alu_en, alu_func, x_sel, y_sel,
        output ir_valid, ir
    );

    modport slave (
        output pm_data, alu_zero,
        input  sync_reset, jmp, jmp_nz, jmp_addr, dont_jmp,
        input  reg_en, src_sel, imm, alu_en, alu_func, x_sel, y_sel,
        input  ir_valid, ir
    );
endinterface

// File: rtl/instruction_decoder.sv
// Instruction register, decode, zero flag and reset synchronizer for the
// 8-bit nanoprocessor; a taken jump squashes the single shadow fetch.
module instruction_decoder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    instruction_decoder_if.master bus
);
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] sync_ff;
    logic [7:0]        ir_q;
    logic              ir_valid_q;
    logic              zero_q;

    logic is_ldi, is_mov, is_alu, is_jmp, is_jnz, taken;

    logic       jmp_c, jmp_nz_c, alu_en_c, x_sel_c, y_sel_c;
    logic [7:0] reg_en_c;
    logic [3:0] src_sel_c;
    logic [2:0] alu_func_c;

    // Flops preset to 1 so sync_reset asserts the moment reset_n drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_ff <= '1;
        else          sync_ff <= {sync_ff[STAGES-2:0], 1'b0};
    end

    assign bus.sync_reset = sync_ff[STAGES-1];

    assign is_ldi = ~ir_q[7];
    assign is_mov = (ir_q[7:6] == 2'b10);
    assign is_alu = (ir_q[7:5] == 3'b110);
    assign is_jmp = (ir_q[7:4] == 4'hE);
    assign is_jnz = (ir_q[7:4] == 4'hF);
    assign taken  = ir_valid_q & (is_jmp | (is_jnz & ~zero_q));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q       <= 8'h00;
            ir_valid_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            ir_q       <= bus.pm_data;
            ir_valid_q <= ~bus.sync_reset & ~taken;
            if (ir_valid_q && is_alu) zero_q <= bus.alu_zero;
        end
    end

    always_comb begin
        jmp_c      = 1'b0;
        jmp_nz_c   = 1'b0;
        alu_en_c   = 1'b0;
        x_sel_c    = 1'b0;
        y_sel_c    = 1'b0;
        reg_en_c   = 8'h00;
        src_sel_c  = 4'd0;
        alu_func_c = 3'd0;
        if (ir_valid_q) begin
            if (is_ldi) begin
                reg_en_c[ir_q[6:4]] = 1'b1;
                src_sel_c           = 4'd8;
            end else if (is_mov) begin
                reg_en_c[ir_q[5:3]] = 1'b1;
                src_sel_c           = {1'b0, ir_q[2:0]};
            end else if (is_alu) begin
                alu_en_c   = 1'b1;
                x_sel_c    = ir_q[4];
                y_sel_c    = ir_q[3];
                alu_func_c = ir_q[2:0];
            end else if (is_jmp) begin
                jmp_c = 1'b1;
            end else begin
                jmp_nz_c = 1'b1;
            end
        end
    end

    assign bus.jmp      = jmp_c;
    assign bus.jmp_nz   = jmp_nz_c;
    assign bus.jmp_addr = ir_q[3:0];
    assign bus.dont_jmp = zero_q;
    assign bus.reg_en   = reg_en_c;
    assign bus.src_sel  = src_sel_c;
    assign bus.imm      = ir_q[3:0];
    assign bus.alu_en   = alu_en_c;
    assign bus.alu_func = alu_func_c;
    assign bus.x_sel    = x_sel_c;
    assign bus.y_sel    = y_sel_c;
    assign bus.ir_valid = ir_valid_q;
    assign bus.ir       = ir_q;
endmodule

// File: tb/tb_instruction_decoder.sv
// Random and directed instruction streams checked against a cycle-level
// reference model of the decoder's architectural behaviour.
module tb_instruction_decoder;
    localparam int STAGES = 2;

    typedef struct packed {
        logic       sync_reset;
        logic       ir_valid;
        logic [7:0] ir;
        logic       dont_jmp;
        logic       jmp;
        logic       jmp_nz;
        logic [3:0] jmp_addr;
        logic [7:0] reg_en;
        logic [3:0] src_sel;
        logic [3:0] imm;
        logic       alu_en;
        logic [2:0] alu_func;
        logic       x_sel;
        logic       y_sel;
    } exp_t;

    localparam int EXP_W = $bits(exp_t);

    logic clk;
    logic reset_n;
    instruction_decoder_if bus ();

    instruction_decoder #(.SYNC_STAGES(STAGES)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    logic [7:0] m_ir;
    bit         m_valid;
    bit         m_flag;
    int         m_edges;
    int         n_vec;
    int         n_err;
    logic [EXP_W-1:0] exp_q[$];

    // Expected outputs from the instruction classes by numeric opcode range.
    function automatic exp_t expect_of(logic [7:0] w, bit v, bit flag, bit sync);
        exp_t e;
        int   d;
        e            = '0;
        e.sync_reset = sync;
        e.ir_valid   = v;
        e.ir         = w;
        e.dont_jmp   = flag;
        e.imm        = w[3:0];
        e.jmp_addr   = w[3:0];
        if (v) begin
            if (w < 8'h80) begin
                d         = int'(w) / 16;
                e.reg_en  = 8'(1 << d);
                e.src_sel = 4'd8;
            end else if (w < 8'hC0) begin
                d         = (int'(w) - 128) / 8;
                e.reg_en  = 8'(1 << d);
                e.src_sel = 4'(int'(w) % 8);
            end else if (w < 8'hE0) begin
                e.alu_en   = 1'b1;
                e.x_sel    = ((int'(w) / 16) % 2) == 1;
                e.y_sel    = ((int'(w) / 8) % 2) == 1;
                e.alu_func = 3'(int'(w) % 8);
            end else if (w < 8'hF0) begin
                e.jmp = 1'b1;
            end else begin
                e.jmp_nz = 1'b1;
            end
        end
        return e;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq("exp_q_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_t'(exp_q.pop_front());
        check_eq("sync_reset", 32'(bus.sync_reset), 32'(e.sync_reset));
        check_eq("ir_valid",   32'(bus.ir_valid),   32'(e.ir_valid));
        check_eq("ir",         32'(bus.ir),         32'(e.ir));
        check_eq("dont_jmp",   32'(bus.dont_jmp),   32'(e.dont_jmp));
        check_eq("jmp",        32'(bus.jmp),        32'(e.jmp));
        check_eq("jmp_nz",     32'(bus.jmp_nz),     32'(e.jmp_nz));
        check_eq("jmp_addr",   32'(bus.jmp_addr),   32'(e.jmp_addr));
        check_eq("reg_en",     32'(bus.reg_en),     32'(e.reg_en));
        check_eq("src_sel",    32'(bus.src_sel),    32'(e.src_sel));
        check_eq("imm",        32'(bus.imm),        32'(e.imm));
        check_eq("alu_en",     32'(bus.alu_en),     32'(e.alu_en));
        check_eq("alu_func",   32'(bus.alu_func),   32'(e.alu_func));
        check_eq("x_sel",      32'(bus.x_sel),      32'(e.x_sel));
        check_eq("y_sel",      32'(bus.y_sel),      32'(e.y_sel));
    endtask

    // ---------------- driver tasks ----------------
    // az is the ALU zero result for the instruction currently held in IR.
    task automatic apply(input logic [7:0] instr, input bit az);
        bit taken;
        bit sync_before;
        bus.pm_data  = instr;
        bus.alu_zero = az;
        @(posedge clk);
        sync_before = (m_edges < STAGES);
        taken = m_valid && ((m_ir >= 8'hE0 && m_ir < 8'hF0) || (m_ir >= 8'hF0 && !m_flag));
        if (m_valid && m_ir >= 8'hC0 && m_ir < 8'hE0) m_flag = az;
        m_valid = !sync_before && !taken;
        if (m_edges < STAGES) m_edges++;
        m_ir = instr;
        exp_q.push_back(expect_of(m_ir, m_valid, m_flag, m_edges < STAGES));
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        m_ir    = 8'h00;
        m_valid = 1'b0;
        m_flag  = 1'b0;
        m_edges = 0;
        exp_q.push_back(expect_of(m_ir, m_valid, m_flag, 1'b1));
        #1;
        check_outputs();
        repeat (cycles) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_vec        = 0;
        n_err        = 0;
        reset_n      = 1'b1;
        bus.pm_data  = 8'h00;
        bus.alu_zero = 1'b0;
        m_ir = 8'h00; m_valid = 1'b0; m_flag = 1'b0; m_edges = 0;
        #2;
        do_reset(3);

        // Jumps fetched while sync_reset is high must not issue.
        apply(8'hE7, 1'b0);
        apply(8'hF3, 1'b0);
        apply(8'h00, 1'b0);

        apply(8'h35, 1'b0);
        apply(8'hA1, 1'b0);

        // jnz not taken after a zero ALU result.
        apply(8'hC2, 1'b0);
        apply(8'hF3, 1'b1);
        apply(8'h11, 1'b0);

        // jnz taken after a non-zero ALU result; shadow squashed.
        apply(8'hC2, 1'b0);
        apply(8'hF3, 1'b0);
        apply(8'h0F, 1'b0);
        apply(8'h22, 1'b0);

        // Unconditional jump, shadow load squashed, target executes.
        apply(8'hE7, 1'b0);
        apply(8'h0F, 1'b0);
        apply(8'h4A, 1'b0);

        // Back-to-back jumps: the second sits in the squashed slot.
        apply(8'hE1, 1'b0);
        apply(8'hE2, 1'b0);
        apply(8'h33, 1'b0);
        apply(8'hB9, 1'b0);
        apply(8'hDD, 1'b0);

        // Reset pulsed while a jump is in IR and the zero flag is set.
        apply(8'hC5, 1'b0);
        apply(8'hE7, 1'b1);
        do_reset(2);
        apply(8'hE3, 1'b0);
        apply(8'h12, 1'b0);
        apply(8'h5C, 1'b0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset($urandom_range(1, 3));
            apply(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/instruction_decoder.md
Name: instruction_decoder

Overview:
- Consumer end of the program-memory/sequencer interface for the 8-bit nanoprocessor.
- Registers the fetched instruction word (pm_data) into an instruction register (IR) and decodes it.
- Drives jmp / jmp_nz / jmp_addr / dont_jmp back to program_sequencer and register-load, source-select and ALU controls to the datapath.
- Owns the zero flag, the branch-shadow flush, and generation of sync_reset from the chip reset.

Parameters:
SYNC_STAGES, 2, number of flops in the reset synchronizer that produces sync_reset (min 2)

Ports:
clk  input  1  system clock, rising-edge
reset_n  input  1  asynchronous active-low reset
pm_data  input  8  instruction word read from program memory at the sequencer's pc
alu_zero  input  1  ALU result-is-zero, valid during an ALU instruction cycle
sync_reset  output  1  synchronous active-high reset to sequencer and datapath
jmp  output  1  unconditional jump request
jmp_nz  output  1  jump-if-not-zero request
jmp_addr  output  4  jump target nibble (sequencer forms {jmp_addr,4'h0})
dont_jmp  output  1  equals zero flag; suppresses jmp_nz in sequencer
reg_en  output  8  one-hot load enable: 0 x0, 1 x1, 2 y0, 3 y1, 4 o_reg, 5 m, 6 i, 7 dm write
src_sel  output  4  datapath source: 0 x0, 1 x1, 2 y0, 3 y1, 4 r, 5 m, 6 i, 7 dm, 8 immediate
imm  output  4  immediate data nibble
alu_en  output  1  load r register with ALU result
alu_func  output  3  ALU function code
x_sel  output  1  ALU x operand: 0 x0, 1 x1
y_sel  output  1  ALU y operand: 0 y0, 1 y1
ir_valid  output  1  IR holds an executable instruction
ir  output  8  instruction register, for debug

Behaviour:
Reset synchronizer:
- reset_n low: all SYNC_STAGES flops set to 1 asynchronously, so sync_reset = 1 immediately.
- After reset_n rises, 0 shifts in; sync_reset falls after exactly SYNC_STAGES rising edges.

Reset values (reset_n low, async):
- ir = 8'h00, ir_valid = 0, zero flag = 0.
- All decode outputs 0; src_sel = 0; sync_reset = 1.

IR update (each rising edge):
- ir <= pm_data.
- ir_valid <= 0 if sync_reset = 1 or a taken jump is in IR this cycle; otherwise ir_valid <= 1.
- A taken jump therefore squashes the one shadow instruction fetched before pc reaches the target.

Decode (combinational from ir, every output gated by ir_valid; when ir_valid = 0 all enables/jumps are 0):
- 0ddd_iiii, load immediate: reg_en[ddd] = 1, src_sel = 8, imm = iiii.
- 10dd_dsss, move: reg_en[ddd] = 1, src_sel = {0,sss}. ddd == sss is legal and still loads.
- 110x_ysss, ALU: alu_en = 1, x_sel = ir[4], y_sel = ir[3], alu_func = ir[2:0].
- 1110_aaaa, jmp: jmp = 1, jmp_addr = aaaa.
- 1111_aaaa, jnz: jmp_nz = 1, jmp_addr = aaaa. Taken only when zero flag = 0.
- imm and jmp_addr are driven from ir[3:0] regardless of opcode. src_sel = 0 when not a load/move.

Zero flag:
- Updates at the edge ending a valid ALU cycle: flag <= alu_zero.
- Holds its value otherwise.
- dont_jmp = flag, registered, so a jnz immediately after an ALU op sees that op's result.

Latency:
- Instruction at pc in cycle t executes in cycle t+1.
- A jump decoded in t+1 makes pc = target in t+2; the target instruction executes in t+3.
- The t+2 slot is squashed.

Boundary cases:
- Back-to-back jumps: the second is in the squashed slot and has no effect.
- reset_n asserted mid-instruction: outputs clear asynchronously and the zero flag clears.
- sync_reset high: ir_valid stays 0, so no spurious jump is issued while the sequencer is in its reset state.

Test Plan:
- Assert reset_n low 3 cycles, release -> sync_reset = 1 for exactly 2 edges after release; ir_valid = 0 until the edge after sync_reset falls; no jmp/reg_en pulses.
- pm_data = 8'h35 -> next cycle reg_en = 8'b0000_1000, src_sel = 8, imm = 4'h5.
- pm_data = 8'hA1 (move x0 <- x1... ddd=4 o_reg, sss=1) -> reg_en = 8'b0001_0000, src_sel = 1.
- ALU 8'hC2 with alu_zero = 1, then jnz 8'hF3 -> dont_jmp = 1, sequencer not redirected, ir_valid stays 1. Repeat with alu_zero = 0 -> jmp_nz taken to 8'h30, next ir_valid = 0 (shadow squashed).
- jmp 8'hE7 followed by load 8'h0F in the shadow -> jmp = 1, jmp_addr = 7; the shadow load has reg_en = 0; the instruction at 8'h70 executes 2 cycles after the jump.
- reset_n pulsed low while a jmp is in IR -> jmp drops to 0 asynchronously, zero flag = 0, sync_reset = 1.
